// File: rtl/barrel_unrotator.sv
// barrel_unrotator
//   Multi-cycle inverse of the barrel rotator. A word that was rotated by
//   'select' positions is rotated back one log2 stage per cycle (S cycles in
//   total, independent of the amount) and presented on a registered output.
//   DIRECTION names the forward rotator's direction; this block undoes it.
//
// Ports
//   clk        clock, all state on posedge
//   rst        synchronous reset, active-high
//   in_valid   data_in/select valid
//   in_ready   block can accept a word (IDLE only, low while rst is high)
//   data_in    rotated word
//   select     rotation amount applied by the forward rotator
//   out_valid  data_out holds the restored word
//   out_ready  consumer accepts data_out
//   data_out   restored word (registered)
//   busy       high while a word is in RUN or DONE
module barrel_unrotator #(
    parameter int unsigned DATA_SIZE = 8,
    parameter bit          DIRECTION = 1'b0,
    localparam int unsigned S        = $clog2(DATA_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic [S-1:0]         select,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 busy
);

    localparam logic [S-1:0] LAST_STAGE = S'(S - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DATA_SIZE-1:0] acc;
    logic [S-1:0]         amt;
    logic [S-1:0]         stage;
    logic [DATA_SIZE-1:0] step;
    logic                 last_stage;

    assign last_stage = (stage == LAST_STAGE);

    // One stage of the inverse rotation: rotate by 2^stage when the matching
    // bit of the captured amount is set. The shift amount is always in
    // 1..DATA_SIZE/2, so both shift terms are well defined.
    always_comb begin
        step = acc;
        for (int unsigned i = 0; i < S; i++) begin
            if ((stage == S'(i)) && amt[i]) begin
                if (DIRECTION == 1'b0) begin
                    step = (acc >> (1 << i)) | (acc << (DATA_SIZE - (1 << i)));
                end else begin
                    step = (acc << (1 << i)) | (acc >> (DATA_SIZE - (1 << i)));
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid)   state_next = RUN;
            RUN:  if (last_stage) state_next = DONE;
            DONE: if (out_ready)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = !rst && (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            amt      <= '0;
            stage    <= '0;
            data_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= data_in;
                        amt   <= select;
                        stage <= '0;
                    end
                end
                RUN: begin
                    acc <= step;
                    if (last_stage) begin
                        data_out <= step;
                    end else begin
                        stage <= stage + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
